// File: rtl/ram32_byte_port.sv
// Byte-serial valid/ready front end for the RAM32 macro: parses command/length
// frames, steers write bytes into lanes and serialises read words back to the host.
module ram32_byte_port (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_data,
    output logic        cmd_ready,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    input  logic        rsp_ready,
    output logic        ram_en,
    output logic [4:0]  ram_a,
    output logic [3:0]  ram_we,
    output logic [31:0] ram_di,
    input  logic [31:0] ram_do,
    output logic        busy
);
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANES  = 4;
    localparam int unsigned IDX_W  = 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_WDATA = 3'd2,
        S_RREQ  = 3'd3,
        S_RCAP  = 3'd4,
        S_RSEND = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic                dir_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DATA_W-1:0]   shreg_q;
    logic                cmd_ready_q;
    logic                rsp_valid_q;
    logic                cmd_xfer;
    logic                rsp_xfer;
    logic                last_byte;

    assign cmd_xfer  = cmd_valid & cmd_ready_q;
    assign rsp_xfer  = rsp_valid_q & rsp_ready;
    assign last_byte = (idx_q == IDX_W'(LANES - 1));

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = shreg_q[7:0];
    assign ram_a     = addr_q;
    assign busy      = (state_q != S_IDLE);

    // Next-state and RAM port drive; write bytes go straight through to the macro.
    always_comb begin
        state_d = state_q;
        ram_en  = 1'b0;
        ram_we  = '0;
        ram_di  = '0;
        case (state_q)
            S_IDLE: begin
                if (cmd_xfer) state_d = S_LEN;
            end
            S_LEN: begin
                if (cmd_xfer) state_d = dir_q ? S_WDATA : S_RREQ;
            end
            S_WDATA: begin
                if (cmd_xfer) begin
                    ram_en = 1'b1;
                    ram_we = LANES'(1) << idx_q;
                    ram_di = DATA_W'(cmd_data) << {idx_q, 3'b000};
                    if (last_byte && (cnt_q == '0)) state_d = S_IDLE;
                end
            end
            S_RREQ: begin
                ram_en  = 1'b1;
                state_d = S_RCAP;
            end
            S_RCAP: begin
                state_d = S_RSEND;
            end
            S_RSEND: begin
                if (rsp_xfer && last_byte) state_d = (cnt_q == '0) ? S_IDLE : S_RREQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame datapath: address, word counter, byte index and read shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q       <= 1'b0;
            addr_q      <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            cmd_ready_q <= (state_d == S_IDLE) || (state_d == S_LEN) || (state_d == S_WDATA);
            rsp_valid_q <= (state_d == S_RSEND);
            case (state_q)
                S_IDLE: begin
                    if (cmd_xfer) begin
                        dir_q  <= cmd_data[7];
                        addr_q <= cmd_data[ADDR_W-1:0];
                    end
                end
                S_LEN: begin
                    if (cmd_xfer) begin
                        cnt_q <= cmd_data[ADDR_W-1:0];
                        idx_q <= '0;
                    end
                end
                S_WDATA: begin
                    if (cmd_xfer) begin
                        idx_q <= idx_q + IDX_W'(1);
                        if (last_byte) begin
                            addr_q <= addr_q + ADDR_W'(1);
                            if (cnt_q != '0) cnt_q <= cnt_q - ADDR_W'(1);
                        end
                    end
                end
                S_RCAP: begin
                    shreg_q <= ram_do;
                end
                S_RSEND: begin
                    if (rsp_xfer) begin
                        shreg_q <= {8'h00, shreg_q[DATA_W-1:8]};
                        idx_q   <= idx_q + IDX_W'(1);
                        if (last_byte) begin
                            addr_q <= addr_q + ADDR_W'(1);
                            if (cnt_q != '0) cnt_q <= cnt_q - ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ram32_byte_port.sv
// Self-checking bench for ram32_byte_port with a behavioural RAM32 macro attached
// and an independent word-array reference of what the RAM should hold.
module tb_ram32_byte_port;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_data = 8'h00;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_ready = 1'b0;
    logic        ram_en;
    logic [4:0]  ram_a;
    logic [3:0]  ram_we;
    logic [31:0] ram_di;
    logic [31:0] ram_do = 32'h0;
    logic        busy;

    int total = 0;
    int bad = 0;

    logic [31:0] mem [32];
    logic [31:0] ref_mem [32];

    always #5 clk = ~clk;

    ram32_byte_port dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .ram_en(ram_en), .ram_a(ram_a), .ram_we(ram_we), .ram_di(ram_di),
        .ram_do(ram_do), .busy(busy)
    );

    // RAM32 macro: byte-lane writes, registered read data.
    always @(posedge clk) begin
        if (ram_en) begin
            for (int i = 0; i < 4; i++)
                if (ram_we[i]) mem[ram_a][8*i +: 8] = ram_di[8*i +: 8];
            if (ram_we == 4'b0000) ram_do <= mem[ram_a];
        end
    end

    task automatic put_byte(input logic [7:0] b);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = b;
        #1;
    endtask

    task automatic test_reset();
        logic [52:0] v;
        rst_n = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            cmd_valid = 1'($urandom);
            cmd_data  = 8'($urandom);
            rsp_ready = 1'($urandom);
            #1;
            v = {cmd_ready, rsp_valid, rsp_data, ram_en, ram_a, ram_we, ram_di, busy};
            total++;
            if (v !== 53'h0) begin
                bad++;
                $display("FAIL reset_outputs cycle=%0d got=%h want=0", c, v);
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release cmd_ready=%b busy=%b want 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_write_burst(input logic [7:0] cmd, input logic [7:0] len_b,
                                    input logic [7:0] data[$]);
        int a = int'(cmd[4:0]);
        logic [3:0]  exp_we;
        logic [31:0] exp_di;
        put_byte(cmd);
        total++;
        if (ram_en !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL wr_cmd_byte ram_en=%b cmd_ready=%b want 0/1", ram_en, cmd_ready);
        end
        @(posedge clk);
        put_byte(len_b);
        total++;
        if (ram_en !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL wr_len_byte ram_en=%b busy=%b cmd_ready=%b want 0/1/1", ram_en, busy, cmd_ready);
        end
        @(posedge clk);
        for (int i = 0; i < data.size(); i++) begin
            int k = i % 4;
            put_byte(data[i]);
            exp_we = 4'(1 << k);
            exp_di = 32'(data[i]) << (8 * k);
            total++;
            if ({ram_en, ram_a, ram_we, ram_di, cmd_ready} !== {1'b1, 5'(a), exp_we, exp_di, 1'b1}) begin
                bad++;
                $display("FAIL wr_byte%0d en=%b a=%0d we=%b di=%h rdy=%b want en=1 a=%0d we=%b di=%h rdy=1",
                         i, ram_en, ram_a, ram_we, ram_di, cmd_ready, a, exp_we, exp_di);
            end
            ref_mem[a][8*k +: 8] = data[i];
            @(posedge clk);
            if (k == 3) a = (a + 1) % 32;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || ram_en !== 1'b0 || ram_we !== 4'b0 || ram_di !== 32'h0) begin
            bad++;
            $display("FAIL wr_end busy=%b en=%b we=%b di=%h want idle zeros", busy, ram_en, ram_we, ram_di);
        end
    endtask

    task automatic test_read_burst(input logic [7:0] cmd, input logic [7:0] len_b);
        int a = int'(cmd[4:0]);
        int words = int'(len_b[4:0]) + 1;
        logic [7:0] exp_b;
        put_byte(cmd);
        @(posedge clk);
        put_byte(len_b);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int w = 0; w < words; w++) begin
            @(negedge clk);
            #1;
            total++;
            if ({ram_en, ram_we, ram_a, cmd_ready, rsp_valid, busy} !== {1'b1, 4'b0, 5'(a), 1'b0, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL rd_req word=%0d en=%b we=%b a=%0d rdy=%b rv=%b busy=%b want en=1 we=0 a=%0d rdy=0 rv=0 busy=1",
                         w, ram_en, ram_we, ram_a, cmd_ready, rsp_valid, busy, a);
            end
            @(negedge clk);
            #1;
            total++;
            if (ram_en !== 1'b0 || rsp_valid !== 1'b0) begin
                bad++;
                $display("FAIL rd_cap word=%0d en=%b rv=%b want 0/0", w, ram_en, rsp_valid);
            end
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                rsp_ready = 1'b1;
                #1;
                exp_b = 8'(ref_mem[a] >> (8 * k));
                total++;
                if (rsp_valid !== 1'b1 || rsp_data !== exp_b) begin
                    bad++;
                    $display("FAIL rd_byte word=%0d byte=%0d rv=%b data=%h want rv=1 data=%h",
                             w, k, rsp_valid, rsp_data, exp_b);
                end
                @(posedge clk);
            end
            a = (a + 1) % 32;
        end
        @(negedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL rd_end busy=%b rv=%b rdy=%b want 0/0/1", busy, rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_single_write();
        logic [7:0] q[$];
        q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33); q.push_back(8'h44);
        test_write_burst(8'h83, 8'h00, q);
    endtask

    task automatic test_read_back();
        test_read_burst(8'h03, 8'h00);
    endtask

    task automatic test_burst_wrap();
        logic [7:0] q[$];
        for (int i = 0; i < 12; i++) q.push_back(8'($urandom));
        test_write_burst(8'h9E, 8'h02, q);
        test_read_burst(8'h1E, 8'h02);
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_b;
        put_byte(8'h07);
        @(posedge clk);
        put_byte(8'hE0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        exp_b = 8'(ref_mem[7]);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            cmd_valid = 1'($urandom);
            cmd_data  = 8'($urandom);
            #1;
            total++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp_b || ram_en !== 1'b0 || cmd_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_stall cycle=%0d rv=%b data=%h en=%b rdy=%b want 1/%h/0/0",
                         c, rsp_valid, rsp_data, ram_en, cmd_ready, exp_b);
            end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            rsp_ready = 1'b1;
            #1;
            exp_b = 8'(ref_mem[7] >> (8 * k));
            total++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp_b) begin
                bad++;
                $display("FAIL bp_byte%0d rv=%b data=%h want 1/%h", k, rsp_valid, rsp_data, exp_b);
            end
            @(posedge clk);
        end
        @(negedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_end busy=%b rdy=%b want 0/1", busy, cmd_ready);
        end
    endtask

    task automatic test_reset_mid_write();
        put_byte(8'h85); @(posedge clk);
        put_byte(8'h00); @(posedge clk);
        put_byte(8'hAA); @(posedge clk);
        put_byte(8'hBB); @(posedge clk);
        ref_mem[5][7:0]  = 8'hAA;
        ref_mem[5][15:8] = 8'hBB;
        @(negedge clk);
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || cmd_ready !== 1'b0 || ram_en !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset busy=%b rdy=%b en=%b want 0/0/0", busy, cmd_ready, ram_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        test_read_burst(8'h05, 8'h00);
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        logic [7:0] start;
        logic [7:0] len_b;
        for (int r = 0; r < 6; r++) begin
            q = {};
            start = 8'($urandom_range(0, 31));
            len_b = 8'($urandom_range(0, 3)) | 8'($urandom_range(0, 7) << 5);
            for (int i = 0; i < 4 * (int'(len_b[4:0]) + 1); i++) q.push_back(8'($urandom));
            test_write_burst(8'h80 | start | 8'($urandom_range(0, 3) << 5), len_b, q);
            test_read_burst(start, len_b);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            ref_mem[i] = $urandom;
            mem[i] = ref_mem[i];
        end
        test_reset();
        test_single_write();
        test_read_back();
        test_burst_wrap();
        test_backpressure();
        test_reset_mid_write();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
